// File: rtl/task_injector_pkg.sv
// Shared types and constants for the task packetizer.
package task_injector_pkg;

  localparam logic [31:0] TASK_ALLOCATION = 32'h40;
  localparam int unsigned HDR_WORDS       = 4;

  typedef enum logic [3:0] {
    StIdle,
    StCapture,
    StSendTarget,
    StSendSize,
    StSendService,
    StSendHdr,
    StSendBin,
`ifdef TASK_PACKETIZER_CSUM_EN
    StSendCsum,
`endif
    StDone
  } state_e;

endpackage

// File: rtl/task_packetizer.sv
// Turns an upstream task stream (4 header words + binary) into a NoC packet.
// Define TASK_PACKETIZER_CSUM_EN to append an XOR checksum flit.
module task_packetizer
  import task_injector_pkg::*;
#(
  parameter int unsigned          FLIT_SIZE = 32,
  parameter logic [FLIT_SIZE-1:0] SERVICE   = FLIT_SIZE'(TASK_ALLOCATION)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic [15:0]          target_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  state_e               state_q, state_d;
  logic [FLIT_SIZE-1:0] hdr_q [HDR_WORDS];
  logic [FLIT_SIZE-1:0] hdr_d [HDR_WORDS];
  logic [15:0]          target_q, target_d;
  logic [1:0]           idx_q, idx_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          sum_sizes;
  logic [31:0]          n_words;
  logic [31:0]          size_flit;
  state_e               after_bin;

`ifdef TASK_PACKETIZER_CSUM_EN
  logic [FLIT_SIZE-1:0] csum_q, csum_d;
  assign size_flit = 32'(HDR_WORDS) + n_words + 32'd1;
  assign after_bin = StSendCsum;
`else
  assign size_flit = 32'(HDR_WORDS) + n_words;
  assign after_bin = StDone;
`endif

  // Binary length in words: (text + data) bytes, wrapping, low bits dropped.
  assign sum_sizes = hdr_q[0][31:0] + hdr_q[1][31:0];
  assign n_words   = sum_sizes >> 2;

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    target_d = target_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
`ifdef TASK_PACKETIZER_CSUM_EN
    csum_d   = csum_q;
`endif
    credit_o = 1'b0;
    tx_o     = 1'b0;
    data_o   = '0;

    unique case (state_q)
      StIdle: begin
        credit_o = 1'b1;
`ifdef TASK_PACKETIZER_CSUM_EN
        csum_d   = '0;
`endif
        if (rx_i) begin
          hdr_d[0] = data_i;
          target_d = target_i;
          idx_d    = 2'd1;
`ifdef TASK_PACKETIZER_CSUM_EN
          csum_d   = data_i;
`endif
          state_d  = StCapture;
        end
      end
      StCapture: begin
        credit_o = 1'b1;
        if (rx_i) begin
          hdr_d[idx_q] = data_i;
`ifdef TASK_PACKETIZER_CSUM_EN
          csum_d       = csum_q ^ data_i;
`endif
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            // hdr[0] and hdr[1] are already registered here
            cnt_d   = n_words;
            state_d = StSendTarget;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      StSendTarget: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(target_q);
        if (credit_i) state_d = StSendSize;
      end
      StSendSize: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(size_flit);
        if (credit_i) state_d = StSendService;
      end
      StSendService: begin
        tx_o   = 1'b1;
        data_o = SERVICE;
        if (credit_i) state_d = StSendHdr;
      end
      StSendHdr: begin
        tx_o   = 1'b1;
        data_o = hdr_q[idx_q];
        if (credit_i) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = (cnt_q == 32'd0) ? after_bin : StSendBin;
        end
      end
      StSendBin: begin
        tx_o     = rx_i;
        credit_o = credit_i;
        data_o   = data_i;
        if (rx_i && credit_i) begin
          cnt_d = cnt_q - 32'd1;
`ifdef TASK_PACKETIZER_CSUM_EN
          csum_d = csum_q ^ data_i;
`endif
          if (cnt_q == 32'd1) state_d = after_bin;
        end
      end
`ifdef TASK_PACKETIZER_CSUM_EN
      StSendCsum: begin
        tx_o   = 1'b1;
        data_o = csum_q;
        if (credit_i) state_d = StDone;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      hdr_q    <= '{default: '0};
      target_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
`ifdef TASK_PACKETIZER_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      target_q <= target_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
`ifdef TASK_PACKETIZER_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: doc/task_packetizer.md
TASK_PACKETIZER -- requirements
Module: task_packetizer

Interface
REQ-001 SHALL have parameter FLIT_SIZE, default 32, flit width in bits.
REQ-002 SHALL have parameter SERVICE, default 32'h00000040, service code placed in the third flit of every packet.
REQ-003 SHALL have one clock; reset is synchronous and active-low. Ports: clk_i (input, 1, clock) and rst_ni (input, 1, synchronous active-low reset).
REQ-004 SHALL have port rx_i (input, 1): upstream flit valid.
REQ-005 SHALL have port credit_o (output, 1): ready to accept an upstream flit.
REQ-006 SHALL have port data_i (input, FLIT_SIZE): upstream flit.
REQ-007 SHALL have port target_i (input, 16): destination PE address; sampled on the first header word.
REQ-008 SHALL have port tx_o (output, 1): NoC flit valid.
REQ-009 SHALL have port credit_i (input, 1): NoC ready.
REQ-010 SHALL have port data_o (output, FLIT_SIZE): NoC flit.
REQ-011 SHALL have port busy_o (output, 1): high in every state except IDLE.
REQ-012 SHALL have port done_o (output, 1): one-cycle pulse after the last flit of a packet transfers.

Function
REQ-013 SHALL accept an upstream word on a rising edge with rx_i=1 and credit_o=1.
REQ-014 SHALL transfer an output flit on a rising edge with tx_o=1 and credit_i=1.
REQ-015 SHALL treat one upstream task stream as: text size, data size, BSS size, entry point, then N binary words, where N = (text+data)>>2 (32-bit sum, wrap on overflow, low 2 bits dropped).
REQ-016 FSM states: IDLE, CAPTURE, SEND_TARGET, SEND_SIZE, SEND_SERVICE, SEND_HDR, SEND_BIN, SEND_CSUM, DONE.
REQ-017 IDLE: credit_o=1; the first accepted word is stored as hdr[0], target_i is latched, next state is CAPTURE.
REQ-018 CAPTURE: credit_o=1; stores hdr[1..3]; after hdr[3] is accepted, next state is SEND_TARGET.
REQ-019 SEND_TARGET/SEND_SIZE/SEND_SERVICE: credit_o=0; tx_o=1; data_o is {zero-extended target}, then size flit, then SERVICE; each state advances on its transfer.
REQ-020 Size flit SHALL equal 4+N, plus 1 when checksum is enabled.
REQ-021 SEND_HDR: emits hdr[0..3] in order, one per transfer, using a 2-bit index.
REQ-022 SEND_BIN: combinational pass-through, tx_o=rx_i, credit_o=credit_i, data_o=data_i; a 32-bit down-counter loaded with N decrements per transfer.
REQ-023 SEND_BIN exits when the counter reaches 0.
REQ-024 When N=0, SEND_BIN SHALL be skipped, going from SEND_HDR directly to SEND_CSUM or DONE.
REQ-025 SEND_CSUM (macro only): emits one checksum flit; credit_o=0.
REQ-026 DONE: done_o=1 for exactly one cycle; tx_o=0; credit_o=0; then IDLE.
REQ-027 A stall (credit_i=0) SHALL hold data_o stable and hold all state.
REQ-028 rx_i=0 in SEND_BIN SHALL insert a bubble with no counter change.
REQ-029 rx_i and credit_o SHALL NOT be combinationally dependent, except on the SEND_BIN pass-through path.
REQ-030 Back-to-back streams: a word presented during DONE SHALL wait (credit_o=0) and be accepted in IDLE.

Reset
REQ-031 On rst_ni=0 at a clock edge: state=IDLE; tx_o=0; data_o=0; done_o=0; busy_o=0; counters, index, hdr[] and checksum=0.
REQ-032 credit_o SHALL be 1 in the first cycle after reset release.
REQ-033 Reset mid-packet SHALL abandon the packet silently with no done_o pulse.

Configuration
REQ-034 Macro TASK_PACKETIZER_CSUM_EN defined: SHALL keep a running XOR of hdr[0..3] and all binary words, zeroed in IDLE, and emit it in SEND_CSUM as the final flit.
REQ-035 Macro TASK_PACKETIZER_CSUM_EN undefined: SHALL omit the SEND_CSUM state and checksum register, and the size flit excludes the checksum.

Structure
REQ-036 Package task_injector_pkg SHALL hold the FSM state enum, the default SERVICE constant TASK_ALLOCATION = 32'h40, and the HDR_WORDS=4 constant.
REQ-037 No sub-module; a single module with one FSM, header buffer and counters.

Verification
REQ-038 Stream 0x8,0x4,0x10,0x0,W0..W2 with target 0x0101, checksum off, credit_i=1: SHALL produce 0x101,0x7,0x40,0x8,0x4,0x10,0x0,W0,W1,W2 and done_o one cycle after W2.
REQ-039 Text=0, data=0: SHALL produce a size flit of 4, no binary flits, and done_o.
REQ-040 credit_i toggling 1-0-1 every cycle during SEND_HDR and SEND_BIN: SHALL produce an identical flit sequence, data_o stable while stalled, and no duplicates.
REQ-041 rst_ni=0 in SEND_BIN after W1: SHALL result in IDLE next cycle, tx_o=0, no done_o, and the next stream packetized correctly.
REQ-042 With TASK_PACKETIZER_CSUM_EN and the REQ-038 stream with W=1,2,3: SHALL produce size flit 8 and last flit 0x8^0x4^0x10^0x0^1^2^3 = 0x1C.
REQ-043 Text=0x6, data=0x1: N SHALL be 1 (truncation) and exactly one binary word SHALL be forwarded.
